gmii_frame_rx: RTL and testbench
================================

# gmii_frame_rx

Receive-side GMII framer for the simple gemac datapath, mirroring the client transmit stream. It strips preamble/SFD from GMII receive data, checks length and CRC-32, and delivers frame bytes with the FCS removed on a non-stallable byte stream with sof/eof/error markers. It also decodes IEEE 802.3x PAUSE frames and reports the received pause quanta to the transmit-side flow-control logic.

## Interface
- MIN_LEN, 64, minimum legal frame length in bytes, counted from the destination address through the FCS.
- MAX_LEN, 1522, maximum legal frame length in bytes, same counting.
- clk  in  1  clock; GMII receive data is synchronous to it.
- reset  in  1  reset, asynchronous, active-low.
- GMII_RX_DV  in  1  receive data valid.
- GMII_RX_ER  in  1  receive error.
- GMII_RXD  in  8  receive data.
- rx_data  out  8  frame byte, FCS excluded.
- rx_valid  out  1  rx_data is valid. There is no backpressure; the consumer must accept every valid cycle.
- rx_sof  out  1  first byte of frame; qualified by rx_valid.
- rx_eof  out  1  last byte of frame; qualified by rx_valid.
- rx_error  out  1  frame is bad; meaningful only with rx_eof.
- pause_rcvd  out  1  one-cycle pulse: a good PAUSE frame was received.
- pause_time  out  16  quanta from the last good PAUSE frame; holds its value until the next one.

## Operation
- All GMII inputs are registered once (dv_r, er_r, rxd_r). All outputs are registered.
- States:
  - WAIT_IDLE (reset state): go to IDLE when dv_r=0.
  - IDLE: when dv_r=1, evaluate the byte in PREAMBLE rules on the same cycle.
  - PREAMBLE:
    - rxd_r=0x55: stay.
    - rxd_r=0xD5: clear the CRC, length and flags; go to DATA.
    - Any other byte: go to DROP.
    - dv_r=0: go to IDLE.
    - Zero or more 0x55 bytes before the SFD are accepted.
  - DATA:
    - Each dv_r=1 cycle pushes rxd_r into a 5-deep delay line and into the CRC, and increments the length counter. The counter saturates at 2047.
    - Any er_r=1 sets the sticky error flag.
    - When a push finds the line full, the oldest byte is emitted with rx_valid=1. rx_sof=1 is set on the first emitted byte of the frame.
    - On dv_r=0, go to END.
  - END (1 cycle):
    - If the line holds fewer than 5 bytes, nothing is emitted.
    - Otherwise the oldest byte is emitted with rx_eof=1. It is also tagged rx_sof=1 if it is the first emitted byte. The other 4 bytes (the FCS) are discarded.
    - rx_error = sticky error OR CRC bad OR length<MIN_LEN OR length>MAX_LEN.
    - Next state is IDLE.
  - DROP: ignore everything until dv_r=0, then go to IDLE. No output.
- CRC-32 algorithm:
  - Reflected, LSB-first, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Computed over the destination address through the last FCS byte.
  - The frame passes iff the register equals 0xDEBB20E3 after the last byte.
- PAUSE decode, using byte offsets after the SFD:
  - Bytes 0–5 = 01-80-C2-00-00-01.
  - Bytes 12–13 = 0x88,0x08.
  - Bytes 14–15 = 0x00,0x01.
  - Bytes 16–17 are captured as pause_time_pending = {b16,b17}.
  - At END, if all fields matched and rx_error would be 0: pause_time <= pending and pause_rcvd=1 for one cycle, coincident with rx_eof.
  - PAUSE frames are still delivered on the rx stream.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_sof=0, rx_eof=0, rx_error=0, pause_rcvd=0, pause_time=0, state=WAIT_IDLE.
- Reset asserted mid-frame: all outputs drop immediately. After release the block stays in WAIT_IDLE until DV has been low for one cycle, so the partial frame is never output.
- Latency: a data byte sampled on GMII_RXD at edge T appears on rx_data at edge T+6. This holds for the final (eof) byte too: for final data byte at T, FCS bytes follow at T+1..T+4 and DV is first low at T+5.
- Output timing:
  - Valid bytes are contiguous, one per cycle, with no gaps within a frame.
  - rx_sof and rx_eof may coincide, on a 5-byte post-SFD frame.
- Interframe gap:
  - A minimum of 1 cycle of DV low between frames is handled.
  - A new frame's PREAMBLE can begin the cycle after END.
  - END emission never overlaps the next frame's output.
- Frames with fewer than 5 post-SFD bytes produce no output at all.

## Test plan
- 64-byte frame (60 data bytes 0x00..0x3B + correct FCS), 7×0x55 + 0xD5 preamble:
  - 60 contiguous valid bytes 0x00..0x3B.
  - sof on 0x00, eof on 0x3B, rx_error=0.
  - First byte appears 6 cycles after its RXD sample.
- Same frame with one data bit flipped -> identical stream, rx_error=1 on eof.
- Same frame with GMII_RX_ER pulsed mid-frame -> rx_error=1 on eof.
- PAUSE frame:
  - Frame: dest 01-80-C2-00-00-01, type 8808, opcode 0001, time 0xBEEF, padded to 64 bytes with good FCS.
  - Response: pause_rcvd pulse coincident with eof, pause_time=0xBEEF.
  - The same frame with a bad FCS leaves pause_time unchanged and gives no pulse.
- Runts and bad preamble:
  - 40-byte frame with good CRC -> rx_error=1.
  - 3-byte post-SFD frame -> no output.
  - Preamble byte 0x57 -> frame dropped, no output.
- Back-to-back frames with 1-cycle DV-low gap, plus reset asserted mid-frame:
  - Both frames are delivered intact.
  - After reset, outputs are 0 and the interrupted frame produces no output. The next frame is received normally.

Source files
------------

// File: rtl/gmii_frame_rx.sv
// GMII receive framer: strips preamble/SFD, checks length and CRC-32, delivers
// frame bytes without FCS, and decodes 802.3x PAUSE frames for flow control.
module gmii_frame_rx #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        GMII_RX_DV,
  input  logic        GMII_RX_ER,
  input  logic [7:0]  GMII_RXD,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_error,
  output logic        pause_rcvd,
  output logic [15:0] pause_time
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    END_FRAME,
    DROP
  } state_t;

  state_t state, state_next;

  logic        dv_r, er_r;
  logic [7:0]  rxd_r;

  logic        start, push, finish;

  logic [4:0][7:0] line;
  logic [2:0]  fill;
  logic [31:0] crc;
  logic [31:0] crc_upd;
  logic [10:0] len;
  logic        err_flag;
  logic        emitted;
  logic        pause_match;
  logic        pause_byte_ok;
  logic [15:0] pause_pending;
  logic        frame_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  assign crc_upd = crc32_byte(crc, rxd_r);

  assign frame_bad = err_flag | er_r | (crc != 32'hDEBB20E3) |
                     (32'(len) < MIN_LEN) | (32'(len) > MAX_LEN);

  // len is the post-SFD offset of the byte currently in rxd_r
  always_comb begin
    pause_byte_ok = 1'b1;
    case (len)
      11'd0:   pause_byte_ok = (rxd_r == 8'h01);
      11'd1:   pause_byte_ok = (rxd_r == 8'h80);
      11'd2:   pause_byte_ok = (rxd_r == 8'hC2);
      11'd3:   pause_byte_ok = (rxd_r == 8'h00);
      11'd4:   pause_byte_ok = (rxd_r == 8'h00);
      11'd5:   pause_byte_ok = (rxd_r == 8'h01);
      11'd12:  pause_byte_ok = (rxd_r == 8'h88);
      11'd13:  pause_byte_ok = (rxd_r == 8'h08);
      11'd14:  pause_byte_ok = (rxd_r == 8'h00);
      11'd15:  pause_byte_ok = (rxd_r == 8'h01);
      default: pause_byte_ok = 1'b1;
    endcase
  end

  // END_FRAME accepts a new preamble byte exactly like IDLE would, so a
  // one-cycle interframe gap loses nothing.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    push       = 1'b0;
    finish     = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (!dv_r) state_next = IDLE;
      end
      IDLE, PREAMBLE, END_FRAME: begin
        if (!dv_r) begin
          state_next = IDLE;
        end else if (rxd_r == 8'h55) begin
          state_next = PREAMBLE;
        end else if (rxd_r == 8'hD5) begin
          state_next = DATA;
          start      = 1'b1;
        end else begin
          state_next = DROP;
        end
      end
      DATA: begin
        if (dv_r) begin
          push = 1'b1;
        end else begin
          finish     = 1'b1;
          state_next = END_FRAME;
        end
      end
      DROP: begin
        if (!dv_r) state_next = IDLE;
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // dv_r resets high so WAIT_IDLE needs a genuine DV-low sample after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_IDLE;
      dv_r  <= 1'b1;
      er_r  <= 1'b0;
      rxd_r <= '0;
    end else begin
      state <= state_next;
      dv_r  <= GMII_RX_DV;
      er_r  <= GMII_RX_ER;
      rxd_r <= GMII_RXD;
    end
  end

  // The eof byte is registered on the DATA->END_FRAME edge to keep the
  // six-cycle latency identical for every byte of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_error      <= 1'b0;
      pause_rcvd    <= 1'b0;
      pause_time    <= '0;
      line          <= '0;
      fill          <= '0;
      crc           <= '1;
      len           <= '0;
      err_flag      <= 1'b0;
      emitted       <= 1'b0;
      pause_match   <= 1'b0;
      pause_pending <= '0;
    end else begin
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_error   <= 1'b0;
      pause_rcvd <= 1'b0;

      if (state == DATA && er_r) err_flag <= 1'b1;

      if (start) begin
        crc         <= '1;
        len         <= '0;
        fill        <= '0;
        err_flag    <= 1'b0;
        emitted     <= 1'b0;
        pause_match <= 1'b1;
      end

      if (push) begin
        line <= {line[3:0], rxd_r};
        crc  <= crc_upd;
        if (len != 11'h7FF) len <= len + 11'd1;
        if (!pause_byte_ok) pause_match <= 1'b0;
        if (len == 11'd16) pause_pending[15:8] <= rxd_r;
        if (len == 11'd17) pause_pending[7:0]  <= rxd_r;
        if (fill == 3'd5) begin
          rx_data  <= line[4];
          rx_valid <= 1'b1;
          rx_sof   <= ~emitted;
          emitted  <= 1'b1;
        end else begin
          fill <= fill + 3'd1;
        end
      end

      if (finish && fill == 3'd5) begin
        rx_data  <= line[4];
        rx_valid <= 1'b1;
        rx_eof   <= 1'b1;
        rx_sof   <= ~emitted;
        emitted  <= 1'b1;
        rx_error <= frame_bad;
        if (pause_match && !frame_bad) begin
          pause_time <= pause_pending;
          pause_rcvd <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_rx.sv
// Directed self-checking bench for gmii_frame_rx.
module tb_gmii_frame_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_error, pause_rcvd;
  logic [15:0] pause_time;

  gmii_frame_rx #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .clk(clk), .reset(reset),
    .GMII_RX_DV(dv), .GMII_RX_ER(er), .GMII_RXD(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_error(rx_error), .pause_rcvd(pause_rcvd), .pause_time(pause_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
    int         cyc;
  } rec_t;

  rec_t q[$];
  rec_t mon_r;
  int   pause_cnt = 0;
  int   pause_cyc = -1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      mon_r.d = rx_data; mon_r.sof = rx_sof; mon_r.eof = rx_eof;
      mon_r.err = rx_error; mon_r.cyc = cyc;
      q.push_back(mon_r);
    end
    if (pause_rcvd === 1'b1) begin
      pause_cnt++;
      pause_cyc = cyc;
    end
  end

  logic [7:0] frm [0:255];
  int frm_len;
  int s_first, s_last;

  function automatic logic [31:0] bench_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic make_seq(input int n, input logic [7:0] mask);
    for (int i = 0; i < n; i++) frm[i] = 8'(i) ^ mask;
    frm_len = n;
  endtask

  task automatic add_fcs();
    logic [31:0] f;
    f = ~bench_crc(frm_len);
    frm[frm_len] = f[7:0]; frm[frm_len+1] = f[15:8];
    frm[frm_len+2] = f[23:16]; frm[frm_len+3] = f[31:24];
    frm_len += 4;
  endtask

  task automatic make_pause(input logic [15:0] t);
    make_seq(60, 8'h00);
    for (int i = 0; i < 60; i++) frm[i] = 8'h00;
    frm[0] = 8'h01; frm[1] = 8'h80; frm[2] = 8'hC2; frm[5] = 8'h01;
    for (int i = 6; i < 12; i++) frm[i] = 8'(8'h10 + i);
    frm[12] = 8'h88; frm[13] = 8'h08; frm[15] = 8'h01;
    frm[16] = t[15:8]; frm[17] = t[7:0];
    add_fcs();
  endtask

  // pre0 replaces the first preamble byte; er pulses on post-SFD byte er_at.
  task automatic send(input logic [7:0] pre0, input int npre, input int er_at, input int gap);
    for (int i = 0; i < npre; i++) begin
      @(negedge clk); dv = 1'b1; rxd = (i == 0) ? pre0 : 8'h55;
    end
    @(negedge clk); dv = 1'b1; rxd = 8'hD5;
    for (int i = 0; i < frm_len; i++) begin
      @(negedge clk); rxd = frm[i]; er = (i == er_at);
      if (i == 0) s_first = cyc;
      if (i == frm_len - 5) s_last = cyc;
    end
    @(negedge clk); dv = 1'b0; rxd = 8'h00; er = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_valid, rx_sof, rx_eof, rx_error, pause_rcvd} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {rx_valid, rx_sof, rx_eof, rx_error, pause_rcvd});
    end
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", rx_data); end
    checks++;
    if (pause_time !== 16'h0000) begin failures++; $display("FAIL reset_pause_time got=%h want=0000", pause_time); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    make_seq(60, 8'h00); add_fcs(); q.delete();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 60) begin
      failures++; $display("FAIL good_count got=%0d want=60", q.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        checks++;
        if (q[i].d !== 8'(i) || q[i].sof !== (i == 0) || q[i].eof !== (i == 59) || q[i].cyc !== q[0].cyc + i) begin
          failures++;
          $display("FAIL good_byte[%0d] got d=%h sof=%b eof=%b cyc=%0d want d=%h sof=%b eof=%b cyc=%0d",
                   i, q[i].d, q[i].sof, q[i].eof, q[i].cyc, 8'(i), i == 0, i == 59, q[0].cyc + i);
        end
      end
      checks++;
      if (q[59].err !== 1'b0) begin failures++; $display("FAIL good_err got=%b want=0", q[59].err); end
      checks++;
      if (q[0].cyc !== s_first + 7) begin failures++; $display("FAIL good_sof_latency got=%0d want=%0d", q[0].cyc, s_first + 7); end
      checks++;
      if (q[59].cyc !== s_last + 7) begin failures++; $display("FAIL good_eof_latency got=%0d want=%0d", q[59].cyc, s_last + 7); end
    end
  endtask

  task automatic test_bad_crc();
    make_seq(60, 8'h00); add_fcs(); frm[10] = frm[10] ^ 8'h04; q.delete();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 60) begin
      failures++; $display("FAIL badcrc_count got=%0d want=60", q.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        checks++;
        if (q[i].d !== ((i == 10) ? 8'h0E : 8'(i)) || q[i].sof !== (i == 0) || q[i].eof !== (i == 59)) begin
          failures++;
          $display("FAIL badcrc_byte[%0d] got d=%h sof=%b eof=%b", i, q[i].d, q[i].sof, q[i].eof);
        end
      end
      checks++;
      if (q[59].err !== 1'b1) begin failures++; $display("FAIL badcrc_err got=%b want=1", q[59].err); end
    end
  endtask

  task automatic test_rx_er();
    make_seq(60, 8'h00); add_fcs(); q.delete();
    send(8'h55, 7, 20, 1); drain();
    checks++;
    if (q.size() !== 60) begin
      failures++; $display("FAIL rxer_count got=%0d want=60", q.size());
    end else begin
      checks++;
      if (q[59].err !== 1'b1 || q[59].eof !== 1'b1) begin
        failures++; $display("FAIL rxer_err got err=%b eof=%b want err=1 eof=1", q[59].err, q[59].eof);
      end
    end
  endtask

  task automatic test_pause();
    make_pause(16'hBEEF); q.delete(); pause_cnt = 0; pause_cyc = -1;
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 60) begin
      failures++; $display("FAIL pause_count got=%0d want=60", q.size());
    end else begin
      checks++;
      if (q[0].d !== 8'h01 || q[16].d !== 8'hBE || q[17].d !== 8'hEF || q[59].err !== 1'b0) begin
        failures++;
        $display("FAIL pause_stream got b0=%h b16=%h b17=%h err=%b want 01 BE EF 0", q[0].d, q[16].d, q[17].d, q[59].err);
      end
      checks++;
      if (pause_cyc !== q[59].cyc) begin failures++; $display("FAIL pause_align got=%0d want=%0d", pause_cyc, q[59].cyc); end
    end
    checks++;
    if (pause_cnt !== 1) begin failures++; $display("FAIL pause_pulses got=%0d want=1", pause_cnt); end
    checks++;
    if (pause_time !== 16'hBEEF) begin failures++; $display("FAIL pause_time got=%h want=BEEF", pause_time); end

    make_pause(16'h1234); frm[frm_len-1] = frm[frm_len-1] ^ 8'h01; q.delete(); pause_cnt = 0;
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (pause_cnt !== 0) begin failures++; $display("FAIL pause_bad_pulses got=%0d want=0", pause_cnt); end
    checks++;
    if (pause_time !== 16'hBEEF) begin failures++; $display("FAIL pause_bad_time got=%h want=BEEF", pause_time); end
    checks++;
    if (q.size() !== 60 || q[q.size()-1].err !== 1'b1) begin
      failures++; $display("FAIL pause_bad_err got count=%0d want count=60 err=1", q.size());
    end
  endtask

  task automatic test_runts();
    make_seq(36, 8'h00); add_fcs(); q.delete();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 36 || q[q.size()-1].eof !== 1'b1 || q[q.size()-1].err !== 1'b1) begin
      failures++; $display("FAIL runt40 got count=%0d want count=36 eof=1 err=1", q.size());
    end

    make_seq(3, 8'h55); q.delete();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 0) begin failures++; $display("FAIL runt3 got count=%0d want=0", q.size()); end

    make_seq(1, 8'h42); add_fcs(); q.delete();
    send(8'h55, 2, -1, 1); drain();
    checks++;
    if (q.size() !== 1) begin
      failures++; $display("FAIL five_count got=%0d want=1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 8'h42 || q[0].sof !== 1'b1 || q[0].eof !== 1'b1 || q[0].err !== 1'b1 || q[0].cyc !== s_last + 7) begin
        failures++;
        $display("FAIL five_byte got d=%h sof=%b eof=%b err=%b cyc=%0d want 42 1 1 1 cyc=%0d",
                 q[0].d, q[0].sof, q[0].eof, q[0].err, q[0].cyc, s_last + 7);
      end
    end

    make_seq(60, 8'h00); add_fcs(); q.delete();
    send(8'h57, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 0) begin failures++; $display("FAIL bad_preamble got count=%0d want=0", q.size()); end
  endtask

  task automatic test_back_to_back();
    q.delete();
    make_seq(60, 8'h00); add_fcs();
    send(8'h55, 7, -1, 1);
    make_seq(60, 8'hA5); add_fcs();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 120) begin
      failures++; $display("FAIL b2b_count got=%0d want=120", q.size());
    end else begin
      for (int i = 0; i < 120; i++) begin
        int j;
        logic [7:0] e;
        j = i % 60;
        e = 8'(j) ^ ((i >= 60) ? 8'hA5 : 8'h00);
        checks++;
        if (q[i].d !== e || q[i].sof !== (j == 0) || q[i].eof !== (j == 59) ||
            (q[i].eof === 1'b1 && q[i].err !== 1'b0) || q[i].cyc !== q[i-j].cyc + j) begin
          failures++;
          $display("FAIL b2b_byte[%0d] got d=%h sof=%b eof=%b err=%b want d=%h sof=%b eof=%b err=0",
                   i, q[i].d, q[i].sof, q[i].eof, q[i].err, e, j == 0, j == 59);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    make_seq(60, 8'h00); add_fcs(); q.delete();
    for (int i = 0; i < 7; i++) begin @(negedge clk); dv = 1'b1; rxd = 8'h55; end
    @(negedge clk); rxd = 8'hD5;
    for (int i = 0; i < frm_len; i++) begin
      @(negedge clk); rxd = frm[i];
      if (i == 30) begin
        checks++;
        if (rx_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre_valid got=%b want=1", rx_valid); end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({rx_valid, rx_sof, rx_eof, rx_error, pause_rcvd} !== 5'b0 || rx_data !== 8'h00 || pause_time !== 16'h0) begin
          failures++;
          $display("FAIL midreset_outputs got flags=%b data=%h ptime=%h want 00000 00 0000",
                   {rx_valid, rx_sof, rx_eof, rx_error, pause_rcvd}, rx_data, pause_time);
        end
        q.delete();
      end
      if (i == 40) reset = 1'b1;
    end
    @(negedge clk); dv = 1'b0; rxd = 8'h00;
    drain();
    checks++;
    if (q.size() !== 0) begin failures++; $display("FAIL midreset_partial got count=%0d want=0", q.size()); end

    make_seq(60, 8'h3C); add_fcs(); q.delete();
    send(8'h55, 7, -1, 1); drain();
    checks++;
    if (q.size() !== 60) begin
      failures++; $display("FAIL midreset_next_count got=%0d want=60", q.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        checks++;
        if (q[i].d !== (8'(i) ^ 8'h3C) || q[i].sof !== (i == 0) || q[i].eof !== (i == 59)) begin
          failures++;
          $display("FAIL midreset_next_byte[%0d] got d=%h sof=%b eof=%b want d=%h", i, q[i].d, q[i].sof, q[i].eof, 8'(i) ^ 8'h3C);
        end
      end
      checks++;
      if (q[59].err !== 1'b0) begin failures++; $display("FAIL midreset_next_err got=%b want=0", q[59].err); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_rx_er();
    test_pause();
    test_runts();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
